// File: rtl/io_port_bank_if.sv
// Register bus between the core's execute stage and io_port_bank.
// Single-cycle strobes; rd_data/rd_valid come back one cycle later.
interface io_port_bank_if #(
  parameter int DATA_W  = 8,
  parameter int PORT_AW = 2
);
  logic              wr_en;
  logic              rd_en;
  logic [PORT_AW-1:0] port_sel;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, rd_en, port_sel, reg_sel, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, port_sel, reg_sel, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/io_port_bank.sv
// N-port I/O bank: per-port input synchroniser, output latch, sticky edge
// flags with interrupt mask, behind a single-cycle register bus.
module io_port_lane #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pin,
  input  logic              armed,
  input  logic              wr_out,
  input  logic              wr_flag,
  input  logic              wr_ien,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] out_q,
  output logic [DATA_W-1:0] in_q,
  output logic [DATA_W-1:0] flag_q,
  output logic [DATA_W-1:0] ien_q,
  output logic              irq_req
);
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] edge_hit;
  logic [DATA_W-1:0] clr_mask;

  assign in_q     = sync_q[SYNC_STAGES-1];
  assign clr_mask = wr_flag ? wr_data : '0;
  assign irq_req  = |(flag_q & ien_q);

  always_comb begin
    edge_hit = '0;
    if (armed) begin
      case (EDGE_MODE)
        0:       edge_hit = in_q & ~prev_q;
        1:       edge_hit = ~in_q & prev_q;
        default: edge_hit = in_q ^ prev_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      out_q  <= '0;
      flag_q <= '0;
      ien_q  <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_q;
      if (wr_out) out_q <= wr_data;
      if (wr_ien) ien_q <= wr_data;
      // OR-ing the new edges in after the clear lets a same-cycle set win
      flag_q <= (flag_q & ~clr_mask) | edge_hit;
    end
  end
endmodule

module io_port_bank #(
  parameter int DATA_W      = 8,
  parameter int N_PORTS     = 4,
  parameter int PORT_AW     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [N_PORTS-1:0][DATA_W-1:0] Input_pins,
  output logic [N_PORTS-1:0][DATA_W-1:0] Output_pins,
  io_port_bank_if.slave                  bus,
  output logic                           irq
);
  localparam int              CW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]   ARM_MAX = CW'(SYNC_STAGES + 1);
  localparam logic [1:0]      REG_OUT  = 2'd0;
  localparam logic [1:0]      REG_IN   = 2'd1;
  localparam logic [1:0]      REG_FLAG = 2'd2;
  localparam logic [1:0]      REG_IEN  = 2'd3;

  logic [CW-1:0] arm_cnt;
  logic          armed;
  logic [N_PORTS-1:0]             port_hit;
  logic [N_PORTS-1:0]             irq_v;
  logic [N_PORTS-1:0][DATA_W-1:0] in_v, flag_v, ien_v;
  logic [DATA_W-1:0]              rd_mux;

  // Holds off edge detection until the synchroniser and prev flop have
  // filled with real pin values after reset release.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                 arm_cnt <= '0;
    else if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + 1'b1;
  end
  assign armed = (arm_cnt == ARM_MAX);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lane
    // Out-of-range selects match no lane, so they fall through harmlessly
    assign port_hit[p] = (bus.port_sel == PORT_AW'(p));

    io_port_lane #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_lane (
      .clk     (Clk),
      .rst_n   (Rst),
      .pin     (Input_pins[p]),
      .armed   (armed),
      .wr_out  (bus.wr_en && port_hit[p] && bus.reg_sel == REG_OUT),
      .wr_flag (bus.wr_en && port_hit[p] && bus.reg_sel == REG_FLAG),
      .wr_ien  (bus.wr_en && port_hit[p] && bus.reg_sel == REG_IEN),
      .wr_data (bus.wr_data),
      .out_q   (Output_pins[p]),
      .in_q    (in_v[p]),
      .flag_q  (flag_v[p]),
      .ien_q   (ien_v[p]),
      .irq_req (irq_v[p])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (port_hit[p]) begin
        case (bus.reg_sel)
          REG_OUT:  rd_mux = Output_pins[p];
          REG_IN:   rd_mux = in_v[p];
          REG_FLAG: rd_mux = flag_v[p];
          default:  rd_mux = ien_v[p];
        endcase
      end
    end
  end

  // Read samples current register values, so a same-cycle write is not seen
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (bus.rd_en) bus.rd_data <= rd_mux;
      bus.rd_valid <= bus.rd_en;
      irq          <= |irq_v;
    end
  end
endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: reads go through a scoreboard queue
// popped by a monitor; pin/irq state is checked directly.
module tb_io_port_bank;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 8-bit, 3 ports, rising edges
  logic [23:0] pins_a, outs_a;
  logic        irq_a;
  io_port_bank_if #(.DATA_W(8), .PORT_AW(2)) bus_a ();
  io_port_bank #(.DATA_W(8), .N_PORTS(3), .PORT_AW(2), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
    .Clk(Clk), .Rst(Rst), .Input_pins(pins_a), .Output_pins(outs_a), .bus(bus_a), .irq(irq_a));

  // Instance B: 16-bit, 2 ports, 3-stage sync, both edges
  logic [31:0] pins_b, outs_b;
  logic        irq_b;
  io_port_bank_if #(.DATA_W(16), .PORT_AW(1)) bus_b ();
  io_port_bank #(.DATA_W(16), .N_PORTS(2), .PORT_AW(1), .SYNC_STAGES(3), .EDGE_MODE(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .Input_pins(pins_b), .Output_pins(outs_b), .bus(bus_b), .irq(irq_b));

  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];

  localparam logic [1:0] R_OUT = 2'd0, R_IN = 2'd1, R_FLAG = 2'd2, R_IEN = 2'd3;

  always @(negedge Clk) begin
    if (Rst && bus_a.rd_valid) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL rd_a: unexpected rd_valid, data %0h", bus_a.rd_data);
      end else begin
        logic [7:0] e;
        e = q_a.pop_front();
        if (bus_a.rd_data !== e) begin
          errors++;
          $display("FAIL rd_a: got %0h expected %0h", bus_a.rd_data, e);
        end
      end
    end
    if (Rst && bus_b.rd_valid) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL rd_b: unexpected rd_valid, data %0h", bus_b.rd_data);
      end else begin
        logic [15:0] e;
        e = q_b.pop_front();
        if (bus_b.rd_data !== e) begin
          errors++;
          $display("FAIL rd_b: got %0h expected %0h", bus_b.rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic acc_a(input bit we, input bit re, input logic [1:0] p, input logic [1:0] r,
                       input logic [7:0] d, input logic [7:0] exp);
    bus_a.wr_en = we; bus_a.rd_en = re; bus_a.port_sel = p; bus_a.reg_sel = r; bus_a.wr_data = d;
    if (re) q_a.push_back(exp);
    tick(1);
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
  endtask

  task automatic acc_b(input bit we, input bit re, input logic p, input logic [1:0] r,
                       input logic [15:0] d, input logic [15:0] exp);
    bus_b.wr_en = we; bus_b.rd_en = re; bus_b.port_sel = p; bus_b.reg_sel = r; bus_b.wr_data = d;
    if (re) q_b.push_back(exp);
    tick(1);
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
  endtask

  initial begin
    bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.port_sel = 0; bus_a.reg_sel = 0; bus_a.wr_data = 0;
    bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.port_sel = 0; bus_b.reg_sel = 0; bus_b.wr_data = 0;
    pins_a = 24'h010101;
    pins_b = 32'h0000_8000;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    tick(10);

    // reset / arming: pins high through release must not set flags
    chk("reset_outs_a", outs_a, 0);
    chk("reset_outs_b", outs_b, 0);
    chk("reset_irq_a", irq_a, 0);
    for (int p = 0; p < 3; p++) acc_a(0, 1, 2'(p), R_FLAG, 0, 8'h00);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);

    // output write visible on the write edge, readback one cycle later
    acc_a(1, 0, 2'd2, R_OUT, 8'hA5, 0);
    chk("out_write_a", outs_a, 24'hA5_0000);
    acc_a(0, 1, 2'd2, R_OUT, 0, 8'hA5);
    tick(1);

    // simultaneous read+write returns the pre-write value
    acc_a(1, 1, 2'd0, R_OUT, 8'h3C, 8'h00);
    chk("out_rw_a", outs_a, 24'hA5_003C);
    acc_a(0, 1, 2'd0, R_OUT, 0, 8'h3C);

    // edge on port 1 bit 3 -> flag at k+2, irq at k+3
    acc_a(1, 0, 2'd1, R_IEN, 8'h08, 0);
    acc_a(0, 1, 2'd1, R_IEN, 0, 8'h08);
    pins_a = 24'h01_09_01;
    tick(2);
    acc_a(0, 1, 2'd1, R_FLAG, 0, 8'h00);
    chk("irq_before", irq_a, 0);
    acc_a(0, 1, 2'd1, R_FLAG, 0, 8'h08);
    chk("irq_rise", irq_a, 1);
    acc_a(1, 0, 2'd1, R_FLAG, 8'hF7, 0);
    acc_a(0, 1, 2'd1, R_FLAG, 0, 8'h08);
    chk("irq_hold", irq_a, 1);
    acc_a(1, 0, 2'd1, R_FLAG, 8'h08, 0);
    chk("irq_lag", irq_a, 1);
    tick(1);
    chk("irq_fall", irq_a, 0);
    acc_a(0, 1, 2'd1, R_FLAG, 0, 8'h00);

    // IN is read-only
    acc_a(1, 0, 2'd1, R_IN, 8'hFF, 0);
    acc_a(0, 1, 2'd1, R_IN, 0, 8'h09);
    chk("in_write_ignored", outs_a, 24'hA5_003C);

    // out-of-range port
    acc_a(1, 0, 2'd3, R_OUT, 8'hFF, 0);
    chk("oor_write", outs_a, 24'hA5_003C);
    acc_a(0, 1, 2'd3, R_OUT, 0, 8'h00);
    acc_a(0, 1, 2'd3, R_FLAG, 0, 8'h00);

    // set/clear collision on port 0 bit 0
    pins_a = 24'h01_09_00;
    tick(4);
    pins_a = 24'h01_09_01;
    tick(2);
    acc_a(1, 1, 2'd0, R_FLAG, 8'h01, 8'h00);
    acc_a(0, 1, 2'd0, R_FLAG, 0, 8'h01);
    chk("irq_masked", irq_a, 0);

    // instance B: outputs, both-edge flags landing 3 edges after sampling
    acc_b(1, 0, 1'b1, R_OUT, 16'h1234, 0);
    chk("out_write_b", outs_b, 32'h1234_0000);
    acc_b(0, 1, 1'b1, R_OUT, 0, 16'h1234);
    pins_b = 32'h0000_0000;
    tick(2);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h8000);
    acc_b(1, 0, 1'b0, R_FLAG, 16'h8000, 0);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    pins_b = 32'h0000_8000;
    tick(2);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h8000);
    chk("irq_b_masked", irq_b, 0);

    // asynchronous reset mid-operation, then re-arm with pins high
    acc_a(1, 0, 2'd1, R_OUT, 8'h77, 0);
    chk("out_write_a1", outs_a, 24'hA5_773C);
    Rst = 1'b0;
    #2;
    chk("async_rst_outs_a", outs_a, 0);
    chk("async_rst_outs_b", outs_b, 0);
    @(posedge Clk);
    #1 Rst = 1'b1;
    tick(10);
    acc_a(0, 1, 2'd0, R_FLAG, 0, 8'h00);
    acc_a(0, 1, 2'd1, R_FLAG, 0, 8'h00);
    acc_a(0, 1, 2'd1, R_OUT, 0, 8'h00);
    acc_b(0, 1, 1'b0, R_FLAG, 0, 16'h0000);
    tick(3);

    chk("sb_a_drained", 64'(q_a.size()), 0);
    chk("sb_b_drained", 64'(q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
